perf_window_collector: RTL
==========================

Name: perf_window_collector

Overview:
- Downstream consumer of the per-unit performance events that currently feed the PERF counter macro.
- Counts up to EVENT_NUM single-bit event strobes over a programmable sampling window of enabled cycles.
- At each window end, snapshots all counts and streams them as one record per event over a valid/ready port to the log/difftest sink.
- Sits next to core top, outside all timing-critical pipelines.

Parameters:
EVENT_NUM, 8, number of event inputs (>=2)
CNT_WIDTH, 32, width of each per-event counter (saturating)
WINDOW_WIDTH, 20, width of cfg_window and the internal window counter
ID_WIDTH, $clog2(EVENT_NUM), derived, width of out_id

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_en  in  1  counting enable
cfg_window  in  WINDOW_WIDTH  window length in enabled cycles; 0 = windowing off
event_i  in  EVENT_NUM  event strobes, one bit per event, sampled every cycle
out_valid  out  1  record valid
out_ready  in  1  sink accepts record
out_id  out  ID_WIDTH  event index of current record
out_count  out  CNT_WIDTH  snapshotted count
out_cycle  out  64  cycle stamp of the window's last cycle
out_last  out  1  record is id EVENT_NUM-1
busy  out  1  drain in progress
overflow  out  1  sticky: a window snapshot was dropped

Behaviour:
- Clocking/reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values:
  - out_valid, busy, overflow, out_id, out_count, out_cycle, out_last = 0.
  - All live counters, the window counter and the 64-bit cycle counter = 0.
  - FSM = IDLE.
- Cycle counter: free-running, +1 every cycle after reset, wraps at 2^64.
- Live counters:
  - When cfg_en=1, each live counter i increments by 1 if event_i[i]=1.
  - Each counter saturates at all-ones and never wraps.
  - When cfg_en=0, counters and window counter hold.
- Window counter:
  - Increments on each enabled cycle.
  - Window end occurs on an enabled cycle where win_cnt == cfg_window-1 and cfg_window != 0.
  - At window end, win_cnt returns to 0.
  - cfg_window=0: no window ends, and counters keep accumulating until saturation.
  - cfg_window changed mid-window: the new value is compared from the next cycle. If win_cnt already exceeds new-1, the window runs until win_cnt wraps around (documented, not an error).
- Window end action, same cycle:
  - snap[i] = live[i] plus this cycle's event (saturated).
  - snap_cycle = cycle counter value.
  - Live counters load 0.
  - Events in the window's last cycle belong to the ending window.
- FSM:
  - IDLE: on window end with a free snapshot -> DRAIN with idx=0. Next cycle out_valid=1.
  - DRAIN:
    - out_valid=1, out_id=idx, out_count=snap[idx], out_cycle=snap_cycle, out_last=(idx==EVENT_NUM-1).
    - Outputs are stable while out_valid && !out_ready.
    - On handshake, idx+1. On handshake with out_last -> IDLE.
  - busy = (state==DRAIN).
- Simultaneous events:
  - Window end while DRAIN with no final handshake this cycle: snapshot dropped, overflow<=1 (sticky until rst), live counters still cleared.
  - Window end in the same cycle as the final handshake: new snapshot accepted, FSM stays DRAIN with idx=0, and the first new record is valid next cycle. No overflow.
- cfg_en=0 during DRAIN: the drain completes normally.
- Reset mid-drain: record abandoned, everything returns to reset values next cycle.
- Latency: window end cycle N -> first record valid at N+1. The minimum drain is EVENT_NUM cycles with out_ready held high.

Decomposition:
- Shared package perf_pkg, holding:
  - perf_record_t struct {id, count, cycle, last}.
  - Enum perf_state_t {IDLE, DRAIN}.
  - Constant PERF_CYCLE_WIDTH=64.
- One sub-module, perf_sat_counter: a CNT_WIDTH saturating counter with inc and clr inputs, where clr has priority but with inc folded into the snapshot path. It is instantiated EVENT_NUM times.

Test Plan:
- Basic window:
  - Stimulus: cfg_window=4, cfg_en=1, event_i[0]=1 every cycle, event_i[1]=1 on alternate cycles, out_ready=1.
  - Response: records id0 count 4, id1 count 2, the other ids count 0. out_last only on id7. out_cycle equals the cycle of the 4th enabled cycle.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles during DRAIN.
  - Response: out_valid stays 1, and out_id/out_count are unchanged until the handshake.
- Overflow:
  - Stimulus: cfg_window=3, out_ready=0 for 10 cycles.
  - Response: overflow=1. The first snapshot is still drained intact, and the next snapshot after the drain holds the count of its own 3-cycle window only.
- Back-to-back:
  - Stimulus: cfg_window=8, EVENT_NUM=8, out_ready=1. The final handshake coincides with the window end.
  - Response: no overflow, and a new id0 record is valid the next cycle.
- Saturation:
  - Stimulus: CNT_WIDTH=4, cfg_window=0 and then set to 20 with event_i[2] held high.
  - Response: out_count for id2 = 15, with no wrap.
- Enable/reset:
  - Stimulus: cfg_en=0 for 6 cycles mid-window.
  - Response: the window end is delayed by 6 cycles and counts are unchanged.
  - Stimulus: rst asserted mid-drain.
  - Response: out_valid=0, overflow=0 and counters=0 the next cycle.

Source files
------------

// File: rtl/perf_pkg.sv
// Shared types and constants for the performance window collector.
package perf_pkg;

  localparam int PERF_CYCLE_WIDTH  = 64;
  localparam int PERF_ID_MAX_WIDTH = 8;
  localparam int PERF_CNT_MAX_WIDTH = 64;

  // Drain state: IDLE waits for a window end, DRAIN streams one record per event.
  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } perf_state_t;

  // One streamed record, laid out at maximum field widths for sinks that
  // pack records into a fixed-format log entry.
  typedef struct packed {
    logic [PERF_ID_MAX_WIDTH-1:0]  id;
    logic [PERF_CNT_MAX_WIDTH-1:0] count;
    logic [PERF_CYCLE_WIDTH-1:0]   cycle;
    logic                          last;
  } perf_record_t;

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating event counter. snap_o is the count including this cycle's
// increment, so a clear in the same cycle does not lose the event: the caller
// captures snap_o while the counter itself reloads zero.
module perf_sat_counter
  import perf_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc_i,
  input  logic                 clr_i,
  output logic [CNT_WIDTH-1:0] snap_o
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic [CNT_WIDTH-1:0] snap_s;
  logic                 sat_s;

  assign sat_s  = &cnt_q;
  assign snap_o = snap_s;

  // Saturated increment, then clear takes priority for the stored value.
  always_comb begin
    snap_s = cnt_q;
    cnt_d  = cnt_q;
    if (inc_i && !sat_s) begin
      snap_s = cnt_q + CNT_WIDTH'(1);
    end else begin
      snap_s = cnt_q;
    end
    if (clr_i) begin
      cnt_d = {CNT_WIDTH{1'b0}};
    end else begin
      cnt_d = snap_s;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/perf_window_collector.sv
// Counts event strobes over a window of enabled cycles, snapshots all counts
// at the window end and streams them as one record per event over valid/ready.
module perf_window_collector
  import perf_pkg::*;
#(
  parameter int EVENT_NUM    = 8,
  parameter int CNT_WIDTH    = 32,
  parameter int WINDOW_WIDTH = 20,
  parameter int ID_WIDTH     = $clog2(EVENT_NUM)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_en,
  input  logic [WINDOW_WIDTH-1:0]     cfg_window,
  input  logic [EVENT_NUM-1:0]        event_i,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ID_WIDTH-1:0]         out_id,
  output logic [CNT_WIDTH-1:0]        out_count,
  output logic [PERF_CYCLE_WIDTH-1:0] out_cycle,
  output logic                        out_last,
  output logic                        busy,
  output logic                        overflow
);

  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(EVENT_NUM - 1);

  perf_state_t                 state_q, state_d;
  logic [PERF_CYCLE_WIDTH-1:0] cycle_q, cycle_d;
  logic [WINDOW_WIDTH-1:0]     win_cnt_q, win_cnt_d;
  logic [CNT_WIDTH-1:0]        snap_q [EVENT_NUM];
  logic                        overflow_q, overflow_d;
  logic                        out_valid_q, out_valid_d;
  logic [ID_WIDTH-1:0]         out_id_q, out_id_d;
  logic [CNT_WIDTH-1:0]        out_count_q, out_count_d;
  logic [PERF_CYCLE_WIDTH-1:0] out_cycle_q, out_cycle_d;
  logic                        out_last_q, out_last_d;

  logic [CNT_WIDTH-1:0]        live_snap_s [EVENT_NUM];
  logic [EVENT_NUM-1:0]        inc_s;
  logic                        win_end_s;
  logic                        handshake_s;
  logic                        final_s;
  logic                        accept_s;
  logic [ID_WIDTH-1:0]         next_id_s;

  assign inc_s       = event_i & {EVENT_NUM{cfg_en}};
  assign win_end_s   = cfg_en && (cfg_window != {WINDOW_WIDTH{1'b0}}) &&
                       (win_cnt_q == (cfg_window - WINDOW_WIDTH'(1)));
  assign handshake_s = out_valid_q && out_ready;
  assign final_s     = handshake_s && out_last_q;
  // A snapshot is taken only when nothing is pending or the last record leaves now.
  assign accept_s    = win_end_s && ((state_q == IDLE) || final_s);
  assign next_id_s   = out_id_q + ID_WIDTH'(1);

  for (genvar g = 0; g < EVENT_NUM; g++) begin : g_cnt
    perf_sat_counter #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .inc_i  (inc_s[g]),
      .clr_i  (win_end_s),
      .snap_o (live_snap_s[g])
    );
  end

  // Next-state for cycle stamp, window counter, drain FSM and record outputs.
  always_comb begin
    state_d     = state_q;
    cycle_d     = cycle_q + PERF_CYCLE_WIDTH'(1);
    overflow_d  = overflow_q | (win_end_s && !accept_s);
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    out_count_d = out_count_q;
    out_cycle_d = out_cycle_q;
    out_last_d  = out_last_q;

    if (win_end_s) begin
      win_cnt_d = {WINDOW_WIDTH{1'b0}};
    end else if (cfg_en) begin
      win_cnt_d = win_cnt_q + WINDOW_WIDTH'(1);
    end else begin
      win_cnt_d = win_cnt_q;
    end

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = DRAIN;
        end else begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (accept_s) begin
          state_d = DRAIN;
        end else if (final_s) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Record 0 comes straight from the live snapshot path; later ones from snap_q.
    if (accept_s) begin
      out_valid_d = 1'b1;
      out_id_d    = {ID_WIDTH{1'b0}};
      out_count_d = live_snap_s[0];
      out_cycle_d = cycle_q;
      out_last_d  = 1'b0;
    end else if (final_s) begin
      out_valid_d = 1'b0;
    end else if (handshake_s) begin
      out_id_d    = next_id_s;
      out_count_d = snap_q[next_id_s];
      out_last_d  = (next_id_s == LAST_ID);
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State, snapshot and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cycle_q     <= {PERF_CYCLE_WIDTH{1'b0}};
      win_cnt_q   <= {WINDOW_WIDTH{1'b0}};
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_id_q    <= {ID_WIDTH{1'b0}};
      out_count_q <= {CNT_WIDTH{1'b0}};
      out_cycle_q <= {PERF_CYCLE_WIDTH{1'b0}};
      out_last_q  <= 1'b0;
      for (int i = 0; i < EVENT_NUM; i++) begin
        snap_q[i] <= {CNT_WIDTH{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      cycle_q     <= cycle_d;
      win_cnt_q   <= win_cnt_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_count_q <= out_count_d;
      out_cycle_q <= out_cycle_d;
      out_last_q  <= out_last_d;
      for (int i = 0; i < EVENT_NUM; i++) begin
        if (accept_s) begin
          snap_q[i] <= live_snap_s[i];
        end else begin
          snap_q[i] <= snap_q[i];
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_count = out_count_q;
  assign out_cycle = out_cycle_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == DRAIN);
  assign overflow  = overflow_q;

endmodule
